// File: rtl/wb_scoreboard.sv
// Writeback arbiter and register scoreboard. It merges ALU and long-latency
// results into one registered register-file write per cycle and tracks busy destinations.
module wb_scoreboard #(
   parameter int DATA_W  = 32,
   parameter int REG_NUM = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lng_valid,
   output logic              lng_ready,
   input  logic [ADDR_W-1:0] lng_rd,
   input  logic [DATA_W-1:0] lng_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] q_rj,
   input  logic [ADDR_W-1:0] q_rk,
   input  logic [ADDR_W-1:0] q_rd,
   output logic              hazard,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              idle
);

   logic [REG_NUM-1:0] busy;
   logic [REG_NUM-1:0] busy_set;
   logic [REG_NUM-1:0] busy_clr;
   logic               hold_valid;
   logic [ADDR_W-1:0]  hold_rd;
   logic [DATA_W-1:0]  hold_data;

   logic               lng_fire;
   logic               sel_load;
   logic [ADDR_W-1:0]  sel_rd;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_wr;

   assign lng_ready = !hold_valid;
   assign lng_fire  = lng_valid && !hold_valid;

   // Output-register source: ALU first, then the parked result, then bypass.
   always_comb begin
      sel_load = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (alu_valid) begin
         sel_load = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end else if (hold_valid) begin
         sel_load = 1'b1;
         sel_rd   = hold_rd;
         sel_data = hold_data;
      end else if (lng_fire) begin
         sel_load = 1'b1;
         sel_rd   = lng_rd;
         sel_data = lng_data;
      end
      sel_wr = sel_load && (sel_rd != '0);
   end

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      for (int unsigned i = 1; i < REG_NUM; i++) begin
         busy_set[i] = issue_valid && (issue_rd == ADDR_W'(i));
         busy_clr[i] = sel_wr && (sel_rd == ADDR_W'(i));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy       <= '0;
         hold_valid <= 1'b0;
         hold_rd    <= '0;
         hold_data  <= '0;
         wb_en      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
      end else begin
         // Set is applied after clear so a same-edge reissue keeps the bit.
         busy <= (busy & ~busy_clr) | busy_set;

         if (alu_valid && lng_fire) begin
            hold_valid <= 1'b1;
            hold_rd    <= lng_rd;
            hold_data  <= lng_data;
         end else if (!alu_valid && hold_valid) begin
            hold_valid <= 1'b0;
         end

         wb_en <= sel_wr;
         if (sel_load) begin
            wb_rd   <= sel_rd;
            wb_data <= sel_data;
         end
      end
   end

   assign hazard = ((q_rj != '0) && busy[q_rj]) ||
                   ((q_rk != '0) && busy[q_rk]) ||
                   ((q_rd != '0) && busy[q_rd]);

   assign idle = (busy == '0) && !hold_valid && !wb_en;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed self-checking bench for wb_scoreboard with hand-computed expectations.
module tb_wb_scoreboard;

   logic        clk;
   logic        reset;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lng_valid;
   logic        lng_ready;
   logic [4:0]  lng_rd;
   logic [31:0] lng_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [4:0]  q_rj;
   logic [4:0]  q_rk;
   logic [4:0]  q_rd;
   logic        hazard;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        idle;

   int vec_cnt = 0;
   int err_cnt = 0;

   wb_scoreboard #(.DATA_W(32), .REG_NUM(32), .ADDR_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lng_valid   (lng_valid),
      .lng_ready   (lng_ready),
      .lng_rd      (lng_rd),
      .lng_data    (lng_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .q_rj        (q_rj),
      .q_rk        (q_rk),
      .q_rd        (q_rd),
      .hazard      (hazard),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .idle        (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lng_valid = 1'b0; lng_rd = '0; lng_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      q_rj = '0; q_rk = '0; q_rd = '0;

      #12;
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_lng_ready", lng_ready, 1);
      chk("rst_hazard", hazard, 0);
      chk("rst_idle", idle, 1);
      tick;
      reset = 1'b1;
      tick;

      // single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      tick;
      alu_valid = 1'b0;
      chk("alu_wb_en", wb_en, 1);
      chk("alu_wb_rd", wb_rd, 5);
      chk("alu_wb_data", wb_data, 32'h1234);
      chk("alu_idle_busy", idle, 0);
      tick;
      chk("alu_wb_en_drop", wb_en, 0);
      chk("alu_wb_rd_keep", wb_rd, 5);
      chk("alu_wb_data_keep", wb_data, 32'h1234);
      chk("alu_idle_after", idle, 1);

      // issue r7, hazard, long bypass clears it
      issue_valid = 1'b1; issue_rd = 5'd7;
      tick;
      issue_valid = 1'b0;
      q_rj = 5'd7;
      #1;
      chk("raw_hazard", hazard, 1);
      chk("raw_idle", idle, 0);
      lng_valid = 1'b1; lng_rd = 5'd7; lng_data = 32'hCAFE;
      #1;
      chk("byp_ready", lng_ready, 1);
      tick;
      lng_valid = 1'b0;
      chk("byp_wb_en", wb_en, 1);
      chk("byp_wb_rd", wb_rd, 7);
      chk("byp_wb_data", wb_data, 32'hCAFE);
      chk("byp_hazard_clr", hazard, 0);
      q_rj = '0;
      tick;

      // set wins over clear on the same index
      issue_valid = 1'b1; issue_rd = 5'd8;
      tick;
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
      tick;
      alu_valid = 1'b0; issue_valid = 1'b0;
      q_rd = 5'd8;
      #1;
      chk("setwin_wb_en", wb_en, 1);
      chk("setwin_hazard", hazard, 1);
      alu_valid = 1'b1; alu_data = 32'h89;
      tick;
      alu_valid = 1'b0;
      chk("setwin_clear", hazard, 0);
      q_rd = '0;
      tick;

      // ALU and long in the same cycle: long parks in hold
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      lng_valid = 1'b1; lng_rd = 5'd4; lng_data = 32'h22;
      tick;
      alu_valid = 1'b0; lng_valid = 1'b0;
      chk("par_c1_rd", wb_rd, 3);
      chk("par_c1_data", wb_data, 32'h11);
      chk("par_c1_ready", lng_ready, 0);
      tick;
      chk("par_c2_en", wb_en, 1);
      chk("par_c2_rd", wb_rd, 4);
      chk("par_c2_data", wb_data, 32'h22);
      chk("par_c2_ready", lng_ready, 1);
      tick;
      chk("par_c3_en", wb_en, 0);
      chk("par_c3_ready", lng_ready, 1);

      // hold full under continuous ALU traffic
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0;
      lng_valid = 1'b1; lng_rd = 5'd11; lng_data = 32'hB1;
      tick;
      lng_rd = 5'd20; lng_data = 32'hDEAD;
      for (int i = 0; i < 4; i++) begin
         chk("str_ready", lng_ready, 0);
         chk("str_en", wb_en, 1);
         chk("str_rd", wb_rd, (i == 0) ? 32'd10 : 32'(11 + i));
         alu_rd = 5'(12 + i); alu_data = 32'(16'hC0 + i);
         tick;
      end
      chk("str_last_rd", wb_rd, 15);
      chk("str_last_data", wb_data, 32'hC3);
      alu_valid = 1'b0; lng_valid = 1'b0;
      tick;
      chk("str_drain_en", wb_en, 1);
      chk("str_drain_rd", wb_rd, 11);
      chk("str_drain_data", wb_data, 32'hB1);
      tick;
      chk("str_after_en", wb_en, 0);
      chk("str_after_ready", lng_ready, 1);
      chk("str_after_idle", idle, 1);

      // index 0 handling
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      tick;
      alu_valid = 1'b0;
      chk("r0_wb_en", wb_en, 0);
      issue_valid = 1'b1; issue_rd = 5'd0;
      tick;
      issue_valid = 1'b0;
      chk("r0_idle", idle, 1);
      chk("r0_hazard", hazard, 0);

      // reset mid-operation with hold full and r9 busy
      issue_valid = 1'b1; issue_rd = 5'd9;
      tick;
      issue_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      lng_valid = 1'b1; lng_rd = 5'd2; lng_data = 32'h2;
      tick;
      lng_valid = 1'b0; alu_rd = 5'd3; alu_data = 32'h3;
      q_rj = 5'd9;
      #1;
      chk("pre_rst_ready", lng_ready, 0);
      chk("pre_rst_hazard", hazard, 1);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_en", wb_en, 0);
      chk("mid_rst_rd", wb_rd, 0);
      chk("mid_rst_data", wb_data, 0);
      chk("mid_rst_idle", idle, 1);
      chk("mid_rst_ready", lng_ready, 1);
      chk("mid_rst_hazard", hazard, 0);
      alu_valid = 1'b0; q_rj = '0;
      tick;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("post_rst_en", wb_en, 0);
         chk("post_rst_idle", idle, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
